// File: rtl/lrm_ctrl_if.sv
// lrm_ctrl_if: groups every handshake and data signal between lrm_ctrl and
// its environment. The environment is the sample producer, the lrm core and
// the result consumer.
//
//   in_*      sample input stream: valid/ready with {x, y, pred}
//   clr       one-cycle pulse that requests a fresh model
//   l_*       lrm core side: reset, ready/valid issue, done/result capture
//   r_*       result stream: valid/ready with {yp, a, b, ab_valid}
//   train_cnt training samples issued to the current model (saturating)
//   err       sticky protocol error (DONE with nothing outstanding)
//
// Modports:
//   slave  - view used by lrm_ctrl
//   master - view used by whatever drives/consumes lrm_ctrl (bench, top level)
interface lrm_ctrl_if;
  // sample input stream
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_x;
  logic [7:0] in_y;
  logic       in_pred;
  logic       clr;

  // lrm core side
  logic       l_reset;
  logic       l_ready;
  logic       l_valid;
  logic [7:0] l_xi;
  logic [7:0] l_yi;
  logic       l_predict;
  logic       l_done;
  logic [7:0] l_yp;
  logic [7:0] l_a;
  logic [7:0] l_b;

  // result stream and status
  logic       r_valid;
  logic       r_ready;
  logic [7:0] r_yp;
  logic [7:0] r_a;
  logic [7:0] r_b;
  logic       r_ab_valid;
  logic [7:0] train_cnt;
  logic       err;

  modport slave (
    input  in_valid, in_x, in_y, in_pred, clr,
    input  l_ready, l_done, l_yp, l_a, l_b,
    input  r_ready,
    output in_ready,
    output l_reset, l_valid, l_xi, l_yi, l_predict,
    output r_valid, r_yp, r_a, r_b, r_ab_valid,
    output train_cnt, err
  );

  modport master (
    output in_valid, in_x, in_y, in_pred, clr,
    output l_ready, l_done, l_yp, l_a, l_b,
    output r_ready,
    input  in_ready,
    input  l_reset, l_valid, l_xi, l_yi, l_predict,
    input  r_valid, r_yp, r_a, r_b, r_ab_valid,
    input  train_cnt, err
  );
endinterface

// File: rtl/lrm_ctrl.sv
// lrm_ctrl: sample sequencer and result scheduler placed in front of a single
// lrm (linear regression) core.
//
// - Buffers incoming {x, y, pred} samples in a show-ahead FIFO and issues the
//   head to the core only when the core reports READY.
// - The core cannot be back-pressured on its result side. For that reason a
//   predict request is issued only while (in-flight predicts + queued
//   results) < RDEPTH. Every DONE therefore has a free result slot.
// - A CLR pulse drains outstanding predictions and then holds the core in
//   reset for one cycle. Buffered samples are kept and later train the new
//   model.
//
// Ports:
//   clk   - clock; all logic is on the rising edge
//   reset - synchronous active-high reset
//   bus   - lrm_ctrl_if.slave (sample input, lrm core side, result output,
//           train_cnt, err)
//
// Parameters:
//   IDEPTH    - input sample FIFO depth (power of 2, >= 2)
//   RDEPTH    - result FIFO depth (power of 2, >= 2)
//   TRAIN_MIN - training samples needed before A/B are meaningful
module lrm_ctrl #(
  parameter int IDEPTH    = 8,
  parameter int RDEPTH    = 4,
  parameter int TRAIN_MIN = 2
) (
  input  logic       clk,
  input  logic       reset,
  lrm_ctrl_if.slave  bus
);

  localparam int IAW = $clog2(IDEPTH);
  localparam int RAW = $clog2(RDEPTH);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    CLRS  = 2'd2
  } state_t;

  state_t state_reg;
  state_t state_next;

  // ------------------------------------------------------------------
  // Input sample FIFO: 17-bit entries {x, y, pred}, show-ahead head.
  // The pointers carry one extra wrap bit so that full and empty can be
  // told apart.
  // ------------------------------------------------------------------
  logic [16:0]  imem [IDEPTH];
  logic [IAW:0] iwr_ptr_reg;
  logic [IAW:0] ird_ptr_reg;
  logic         iempty;
  logic         ifull;
  logic         ipush;
  logic         ipop;
  logic [16:0]  ihead;
  logic [7:0]   head_x;
  logic [7:0]   head_y;
  logic         head_pred;

  assign iempty = (iwr_ptr_reg == ird_ptr_reg);
  assign ifull  = (iwr_ptr_reg[IAW] != ird_ptr_reg[IAW]) &&
                  (iwr_ptr_reg[IAW-1:0] == ird_ptr_reg[IAW-1:0]);

  // A full FIFO refuses a push even when a pop happens on the same edge.
  // This keeps in_ready independent of the issue path.
  assign ipush = bus.in_valid & ~ifull;

  assign ihead     = imem[ird_ptr_reg[IAW-1:0]];
  assign head_x    = ihead[16:9];
  assign head_y    = ihead[8:1];
  assign head_pred = ihead[0];

  always_ff @(posedge clk) begin
    if (ipush) begin
      imem[iwr_ptr_reg[IAW-1:0]] <= {bus.in_x, bus.in_y, bus.in_pred};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      iwr_ptr_reg <= '0;
      ird_ptr_reg <= '0;
    end else begin
      if (ipush) begin
        iwr_ptr_reg <= iwr_ptr_reg + 1'b1;
      end
      if (ipop) begin
        ird_ptr_reg <= ird_ptr_reg + 1'b1;
      end
    end
  end

  // ------------------------------------------------------------------
  // Result FIFO: 25-bit entries {yp, a, b, ab_valid}.
  // ------------------------------------------------------------------
  logic [24:0]  rmem [RDEPTH];
  logic [RAW:0] rwr_ptr_reg;
  logic [RAW:0] rrd_ptr_reg;
  logic [RAW:0] rcount;
  logic         rempty;
  logic         rfull;
  logic         rpush;
  logic         rpop;
  logic [24:0]  rhead;
  logic         ab_valid_now;

  assign rcount = rwr_ptr_reg - rrd_ptr_reg;
  assign rempty = (rwr_ptr_reg == rrd_ptr_reg);
  assign rfull  = (rwr_ptr_reg[RAW] != rrd_ptr_reg[RAW]) &&
                  (rwr_ptr_reg[RAW-1:0] == rrd_ptr_reg[RAW-1:0]);
  assign rpop   = ~rempty & bus.r_ready;
  assign rhead  = rmem[rrd_ptr_reg[RAW-1:0]];

  // ------------------------------------------------------------------
  // Outstanding predictions, training count, error flag
  // ------------------------------------------------------------------
  logic [RAW:0]   outstanding_reg;
  logic [RAW:0]   outstanding_next;
  logic [7:0]     train_cnt_reg;
  logic [7:0]     train_cnt_next;
  logic           err_reg;
  logic           capture;
  logic           done_orphan;
  logic           credit;
  logic           issue;
  logic           issue_train;
  logic           issue_pred;
  logic [RAW+1:0] committed;

  // Credit counts both the predictions still inside the core and the
  // results that are waiting to be popped. Both are pre-edge values, so a
  // slot freed by a pop on this edge is used only from the next cycle.
  assign committed = {1'b0, outstanding_reg} + {1'b0, rcount};
  assign credit    = committed < (RAW+2)'(RDEPTH);

  assign capture     = bus.l_done & (outstanding_reg != '0);
  assign done_orphan = bus.l_done & (outstanding_reg == '0);

  // The credit rule already keeps capture from ever meeting a full FIFO.
  // The extra full check only protects stored results against a
  // misbehaving core.
  assign rpush        = capture & ~rfull;
  assign ab_valid_now = (train_cnt_reg >= 8'(TRAIN_MIN));

  always_ff @(posedge clk) begin
    if (rpush) begin
      rmem[rwr_ptr_reg[RAW-1:0]] <= {bus.l_yp, bus.l_a, bus.l_b, ab_valid_now};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rwr_ptr_reg <= '0;
      rrd_ptr_reg <= '0;
    end else begin
      if (rpush) begin
        rwr_ptr_reg <= rwr_ptr_reg + 1'b1;
      end
      if (rpop) begin
        rrd_ptr_reg <= rrd_ptr_reg + 1'b1;
      end
    end
  end

  // ------------------------------------------------------------------
  // Issue: only in RUN. A predict without credit stalls the head, and
  // samples behind it wait in order.
  // ------------------------------------------------------------------
  assign issue = (state_reg == RUN) & bus.l_ready & ~iempty &
                 (~head_pred | credit);
  assign issue_train = issue & ~head_pred;
  assign issue_pred  = issue & head_pred;
  assign ipop        = issue;

  always_comb begin
    outstanding_next = outstanding_reg;
    case ({issue_pred, capture})
      2'b10:   outstanding_next = outstanding_reg + 1'b1;
      2'b01:   outstanding_next = outstanding_reg - 1'b1;
      default: outstanding_next = outstanding_reg;
    endcase
  end

  always_comb begin
    train_cnt_next = train_cnt_reg;
    if (state_reg == CLRS) begin
      train_cnt_next = '0;
    end else if (issue_train && (train_cnt_reg != 8'hFF)) begin
      train_cnt_next = train_cnt_reg + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      outstanding_reg <= '0;
      train_cnt_reg   <= '0;
      err_reg         <= 1'b0;
    end else begin
      outstanding_reg <= outstanding_next;
      train_cnt_reg   <= train_cnt_next;
      if (done_orphan) begin
        err_reg <= 1'b1;
      end
    end
  end

  // ------------------------------------------------------------------
  // Clear sequencing FSM
  // ------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= RUN;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      RUN: begin
        // An issue on this same edge still happens. DRAIN then waits for
        // its result.
        if (bus.clr) begin
          state_next = DRAIN;
        end
      end
      DRAIN: begin
        if (outstanding_reg == '0) begin
          state_next = CLRS;
        end
      end
      CLRS: begin
        state_next = RUN;
      end
      default: begin
        state_next = RUN;
      end
    endcase
  end

  // ------------------------------------------------------------------
  // Outputs
  // ------------------------------------------------------------------
  assign bus.in_ready  = ~ifull;

  assign bus.l_reset   = reset | (state_reg == CLRS);
  assign bus.l_valid   = issue;
  assign bus.l_xi      = iempty ? 8'd0 : head_x;
  assign bus.l_yi      = iempty ? 8'd0 : head_y;
  assign bus.l_predict = iempty ? 1'b0 : head_pred;

  assign bus.r_valid    = ~rempty;
  assign bus.r_yp       = rhead[24:17];
  assign bus.r_a        = rhead[16:9];
  assign bus.r_b        = rhead[8:1];
  assign bus.r_ab_valid = rhead[0];

  assign bus.train_cnt = train_cnt_reg;
  assign bus.err       = err_reg;

endmodule
